// File: rtl/bus_control_unit.sv
// bus_control_unit: Moore FSM sequencing fetch, decode and execute for a
// 16-bit accumulator datapath sharing a single bus.
// Optional macro CU_MEM_WAIT_EN: when defined, E2 of LDAC/STAC is stretched
// until dm_ready is high; when undefined, E2 lasts exactly one cycle.
module bus_control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus,
  input  logic        z_flag,
  input  logic        dm_ready,
  output logic        PC_read_en,
  output logic        AR_read_en,
  output logic        AC_read_en,
  output logic        R_read_en,
  output logic        IM_read_en,
  output logic        DM_read_en,
  output logic        DR_read_en,
  output logic        PC_write_en,
  output logic        AR_write_en,
  output logic        AC_write_en,
  output logic        R_write_en,
  output logic        DR_write_en,
  output logic        DM_write_en,
  output logic        PC_inc_en,
  output logic        alu_en,
  output logic [1:0]  alu_op,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F1   = 3'd1,
    F2   = 3'd2,
    DEC  = 3'd3,
    E1   = 3'd4,
    E2   = 3'd5,
    HALT = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDAC  = 4'd1;
  localparam logic [3:0] OP_STAC  = 4'd2;
  localparam logic [3:0] OP_MVACR = 4'd3;
  localparam logic [3:0] OP_MVRAC = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_JMPZ  = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;
  localparam logic [3:0] OP_HALT  = 4'd15;

  state_t     state, state_nx;
  logic [3:0] opcode, opcode_nx;
  logic       mem_done;

  // Only the opcode field of the bus matters here; the operand bits (and
  // dm_ready in the single-cycle memory build) are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{bus[11:0], dm_ready};

`ifdef CU_MEM_WAIT_EN
  assign mem_done = dm_ready;
`else
  assign mem_done = 1'b1;
`endif

  // State and opcode registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opcode <= 4'd0;
    end else begin
      state  <= state_nx;
      opcode <= opcode_nx;
    end
  end

  // Next-state and Moore output decode from the current state and latched opcode.
  always_comb begin
    state_nx    = state;
    opcode_nx   = opcode;
    PC_read_en  = 1'b0;
    AR_read_en  = 1'b0;
    AC_read_en  = 1'b0;
    R_read_en   = 1'b0;
    IM_read_en  = 1'b0;
    DM_read_en  = 1'b0;
    DR_read_en  = 1'b0;
    PC_write_en = 1'b0;
    AR_write_en = 1'b0;
    AC_write_en = 1'b0;
    R_write_en  = 1'b0;
    DR_write_en = 1'b0;
    DM_write_en = 1'b0;
    PC_inc_en   = 1'b0;
    alu_en      = 1'b0;
    alu_op      = 2'b00;
    halted      = 1'b0;
    case (state)
      IDLE: state_nx = F1;
      F1: begin
        PC_read_en  = 1'b1;
        AR_write_en = 1'b1;
        state_nx    = F2;
      end
      F2: begin
        IM_read_en  = 1'b1;
        DR_write_en = 1'b1;
        PC_inc_en   = 1'b1;
        opcode_nx   = bus[15:12];
        state_nx    = DEC;
      end
      DEC: begin
        case (opcode)
          OP_LDAC, OP_STAC, OP_MVACR, OP_MVRAC,
          OP_ADD, OP_SUB, OP_JMP, OP_INC: state_nx = E1;
          OP_JMPZ: state_nx = z_flag ? E1 : F1;
          OP_HALT: state_nx = HALT;
          default: state_nx = F1;
        endcase
      end
      E1: begin
        state_nx = F1;
        case (opcode)
          OP_LDAC, OP_STAC: begin
            DR_read_en  = 1'b1;
            AR_write_en = 1'b1;
            state_nx    = E2;
          end
          OP_MVACR: begin
            AC_read_en = 1'b1;
            R_write_en = 1'b1;
          end
          OP_MVRAC: begin
            R_read_en   = 1'b1;
            AC_write_en = 1'b1;
          end
          OP_ADD: begin
            alu_en = 1'b1;
            alu_op = 2'b00;
          end
          OP_SUB: begin
            alu_en = 1'b1;
            alu_op = 2'b01;
          end
          OP_INC: begin
            alu_en = 1'b1;
            alu_op = 2'b10;
          end
          OP_JMP, OP_JMPZ: begin
            DR_read_en  = 1'b1;
            PC_write_en = 1'b1;
          end
          default: state_nx = F1;
        endcase
      end
      E2: begin
        state_nx = mem_done ? F1 : E2;
        if (opcode == OP_LDAC) begin
          DM_read_en  = 1'b1;
          AC_write_en = 1'b1;
        end else if (opcode == OP_STAC) begin
          AC_read_en  = 1'b1;
          DM_write_en = 1'b1;
        end
      end
      HALT: halted = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

endmodule
